// File: rtl/ema_pkg.sv
// ---------------------------------------------------------------------------
// ema_pkg
//   Shared types and helpers for the EMA burst/capture block.
//   - state_e        : run-level FSM states
//   - ACC_W          : accumulator width for the default build (ADC_W + clog2(MAX_SHOTS))
//   - acc_width()    : the same formula for any parameter set
//   - clamp_*()      : sanitise the runtime configuration when it is latched
// ---------------------------------------------------------------------------
package ema_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    BURST = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DEF_ADC_W     = 12;
  localparam int DEF_MAX_SHOTS = 16;

  function automatic int acc_width(input int adc_w, input int max_shots);
    return adc_w + $clog2(max_shots);
  endfunction

  localparam int ACC_W = acc_width(DEF_ADC_W, DEF_MAX_SHOTS);

  // Half-pulse length of zero would give no pulse at all; treat it as one cycle.
  function automatic logic [7:0] clamp_half(input logic [7:0] h);
    return (h == 8'd0) ? 8'd1 : h;
  endfunction

  function automatic logic [3:0] clamp_pulses(input logic [3:0] p);
    return (p == 4'd0) ? 4'd1 : p;
  endfunction

  function automatic logic [4:0] clamp_shots(input logic [4:0] s, input int max_shots);
    if (s == 5'd0) return 5'd1;
    if (int'(s) > max_shots) return 5'(max_shots);
    return s;
  endfunction

  // Zero or anything past the end of the buffer means "fill the whole buffer".
  function automatic int unsigned clamp_samples(input int unsigned s, input int unsigned depth);
    return ((s == 0) || (s > depth)) ? depth : s;
  endfunction

endpackage

// File: rtl/ema_acc_ram.sv
// ---------------------------------------------------------------------------
// ema_acc_ram
//   Simple dual-port accumulation buffer, DEPTH x DATA_W, one write port and
//   one read port with a single registered read stage (block-RAM friendly).
//   Ports:
//     clk_i    clock
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     raddr_i  read address
//     rdata_o  read data, valid one cycle after raddr_i
// ---------------------------------------------------------------------------
module ema_acc_ram #(
  parameter int DEPTH  = 15000,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ema_burst_capture.sv
// ---------------------------------------------------------------------------
// ema_burst_capture
//   Latches a runtime config on a START rising edge, waits cfg_delay cycles,
//   drives a P/N half-pulse burst, and captures cfg_samples ADC samples per
//   shot into an on-chip buffer, summing across cfg_shots shots. In DONE the
//   sums are read out over the FSMC strobe, one word per OE rising edge.
//   Ports:
//     clk_80mhz    system clock
//     pll_locked   synchronous active-low reset
//     START_FPGA   asynchronous start request (rising edge)
//     cfg_*        run configuration, sampled only when a run is accepted
//     adc_data     ADC sample, valid every clock
//     EMA_PULSE_P  active-low P drive
//     EMA_PULSE_N  active-low N drive
//     ON_32        active-low driver enable
//     CTRL_SW      tied low
//     FPGA_OE      asynchronous FSMC read strobe, active low
//     FSMC_D       readout word, zero-extended sum
//     busy         run in progress (DELAY/BURST/CAPT)
//     done         all shots captured, readout enabled
// ---------------------------------------------------------------------------
module ema_burst_capture
  import ema_pkg::*;
#(
  parameter int ADC_W     = 12,
  parameter int DEPTH     = 15000,
  parameter int ADDR_W    = 14,
  parameter int CNT_W     = 24,
  parameter int MAX_SHOTS = 16
) (
  input  logic              clk_80mhz,
  input  logic              pll_locked,
  input  logic              START_FPGA,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [7:0]        cfg_half,
  input  logic [7:0]        cfg_gap,
  input  logic [3:0]        cfg_pulses,
  input  logic [ADDR_W-1:0] cfg_samples,
  input  logic [4:0]        cfg_shots,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              EMA_PULSE_P,
  output logic              EMA_PULSE_N,
  output logic              ON_32,
  output logic              CTRL_SW,
  input  logic              FPGA_OE,
  output logic [15:0]       FSMC_D,
  output logic              busy,
  output logic              done
);

  localparam int SUM_W = acc_width(ADC_W, MAX_SHOTS);
  // One extra bit so a sample count equal to 2**ADDR_W would still fit.
  localparam int NS_W  = ADDR_W + 1;

  state_e state_q, state_d;

  // Synchronisers: [0] and [1] are the 2-flop chain, [2] holds the previous
  // synchronised value for edge detection.
  logic [2:0] start_sync_q;
  logic [2:0] oe_sync_q;
  logic       start_pulse;
  logic       oe_rise;
  logic       start_go;

  // Latched, clamped configuration.
  logic [CNT_W-1:0] dly_q;
  logic [7:0]       half_q;
  logic [7:0]       gap_q;
  logic [3:0]       npulse_q;
  logic [NS_W-1:0]  nsamp_q;
  logic [4:0]       nshots_q;

  // Delay and burst counters.
  logic [CNT_W-1:0] dly_cnt_q;
  logic [9:0]       ph_q;
  logic [3:0]       pc_q;
  logic [9:0]       half2;
  logic [9:0]       per_len;
  logic             dly_last;
  logic             burst_last;
  logic             per_last;

  // Capture / accumulate pipeline.
  logic              cap_run_q;
  logic [ADDR_W-1:0] cap_cnt_q;
  logic              cap_last;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_last_q;
  logic [ADC_W-1:0]  adc_q;
  logic              cap_fin_q;
  logic [4:0]        shot_idx_q;
  logic              shot_end;
  logic              burst_entry;

  // Readout.
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              rd_vld_q;
  logic [15:0]       fsmc_q;

  // RAM hookup.
  logic [ADDR_W-1:0] ram_raddr;
  logic [SUM_W-1:0]  ram_rdata;
  logic [SUM_W-1:0]  ram_wdata;
  logic              ram_we;

  assign start_pulse = start_sync_q[1] & ~start_sync_q[2];
  assign oe_rise     = oe_sync_q[1] & ~oe_sync_q[2];
  assign start_go    = start_pulse && ((state_q == IDLE) || (state_q == DONE));

  assign half2    = {1'b0, half_q, 1'b0};
  assign per_len  = half2 + {2'b00, gap_q};
  assign dly_last = (dly_q <= CNT_W'(1)) || (dly_cnt_q == dly_q - CNT_W'(1));
  // The last pulse ends after its N half; the gap is only inserted between pulses.
  assign burst_last = (ph_q == half2 - 10'd1) && (pc_q == npulse_q - 4'd1);
  assign per_last   = (ph_q == per_len - 10'd1);

  assign cap_last    = cap_run_q && ({1'b0, cap_cnt_q} == nsamp_q - NS_W'(1));
  assign shot_end    = (state_q == CAPT) && cap_fin_q;
  assign burst_entry = (state_q == DELAY) && (state_d == BURST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_pulse) state_d = DELAY;
      end
      DELAY: begin
        if (dly_last) state_d = BURST;
      end
      BURST: begin
        if (burst_last) state_d = CAPT;
      end
      CAPT: begin
        if (cap_fin_q) begin
          state_d = ((shot_idx_q + 5'd1) == nshots_q) ? DONE : DELAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Drive outputs are decoded from registered state and counters only.
  // The enable comes up one cycle into DELAY so the driver settles before
  // the first edge, and drops as soon as the burst leaves BURST.
  always_comb begin
    EMA_PULSE_P = 1'b1;
    EMA_PULSE_N = 1'b1;
    ON_32       = 1'b1;
    if (state_q == BURST) begin
      ON_32 = 1'b0;
      if (ph_q < {2'b00, half_q}) begin
        EMA_PULSE_P = 1'b0;
      end else if (ph_q < half2) begin
        EMA_PULSE_N = 1'b0;
      end
    end else if ((state_q == DELAY) && (dly_cnt_q != '0)) begin
      ON_32 = 1'b0;
    end
  end

  assign CTRL_SW = 1'b0;
  assign busy    = (state_q == DELAY) || (state_q == BURST) || (state_q == CAPT);
  assign done    = (state_q == DONE);
  assign FSMC_D  = fsmc_q;

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_80mhz) begin
    if (!pll_locked) begin
      state_q      <= IDLE;
      start_sync_q <= 3'b000;
      oe_sync_q    <= 3'b111;
      dly_q        <= '0;
      half_q       <= 8'd1;
      gap_q        <= '0;
      npulse_q     <= 4'd1;
      nsamp_q      <= NS_W'(1);
      nshots_q     <= 5'd1;
      dly_cnt_q    <= '0;
      ph_q         <= '0;
      pc_q         <= '0;
      cap_run_q    <= 1'b0;
      cap_cnt_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_last_q    <= 1'b0;
      adc_q        <= '0;
      cap_fin_q    <= 1'b0;
      shot_idx_q   <= '0;
      rd_ptr_q     <= '0;
      rd_vld_q     <= 1'b0;
      fsmc_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_sync_q <= {start_sync_q[1:0], START_FPGA};
      oe_sync_q    <= {oe_sync_q[1:0], FPGA_OE};

      if (start_go) begin
        dly_q    <= cfg_delay;
        half_q   <= clamp_half(cfg_half);
        gap_q    <= cfg_gap;
        npulse_q <= clamp_pulses(cfg_pulses);
        nsamp_q  <= NS_W'(clamp_samples(32'(cfg_samples), DEPTH));
        nshots_q <= clamp_shots(cfg_shots, MAX_SHOTS);
      end

      dly_cnt_q <= (state_q == DELAY) ? dly_cnt_q + CNT_W'(1) : '0;

      if (state_q == BURST) begin
        if (per_last) begin
          ph_q <= '0;
          pc_q <= pc_q + 4'd1;
        end else begin
          ph_q <= ph_q + 10'd1;
        end
      end else begin
        ph_q <= '0;
        pc_q <= '0;
      end

      // Read address 0 is issued on the first BURST cycle.
      if (burst_entry) begin
        cap_run_q <= 1'b1;
        cap_cnt_q <= '0;
      end else if (cap_run_q) begin
        cap_cnt_q <= cap_cnt_q + ADDR_W'(1);
        if (cap_last) cap_run_q <= 1'b0;
      end

      // The sample is taken in the same cycle its address is read; the sum
      // is written back the following cycle when the RAM data arrives.
      wr_en_q   <= cap_run_q;
      wr_addr_q <= cap_cnt_q;
      wr_last_q <= cap_last;
      adc_q     <= adc_data;

      if (burst_entry) begin
        cap_fin_q <= 1'b0;
      end else if (wr_last_q) begin
        cap_fin_q <= 1'b1;
      end

      if (start_go) begin
        shot_idx_q <= '0;
      end else if (shot_end) begin
        shot_idx_q <= shot_idx_q + 5'd1;
      end

      if (start_go) begin
        rd_ptr_q <= '0;
      end else if ((state_q == DONE) && oe_rise) begin
        rd_ptr_q <= ({1'b0, rd_ptr_q} == nsamp_q - NS_W'(1)) ? '0 : rd_ptr_q + ADDR_W'(1);
      end

      // rd_vld_q masks the first DONE cycle, when the RAM output still holds
      // a word fetched with the accumulate address.
      rd_vld_q <= (state_q == DONE);
      if ((state_q == DONE) && (state_d == DONE) && rd_vld_q) begin
        fsmc_q <= 16'(ram_rdata);
      end else begin
        fsmc_q <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Accumulation buffer
  // -------------------------------------------------------------------------
  assign ram_raddr = (state_q == DONE) ? rd_ptr_q : cap_cnt_q;
  // The first shot overwrites whatever the buffer held before.
  assign ram_wdata = ((shot_idx_q == 5'd0) ? '0 : ram_rdata) + SUM_W'(adc_q);
  assign ram_we    = wr_en_q & pll_locked;

  ema_acc_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (SUM_W)
  ) u_ram (
    .clk_i   (clk_80mhz),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_ema_burst_capture.sv
module tb_ema_burst_capture;

  localparam int ADC_W     = 12;
  localparam int DEPTH     = 15000;
  localparam int ADDR_W    = 14;
  localparam int CNT_W     = 24;
  localparam int MAX_SHOTS = 16;

  logic              clk_80mhz = 1'b0;
  logic              pll_locked = 1'b0;
  logic              START_FPGA = 1'b0;
  logic              FPGA_OE = 1'b1;
  logic [CNT_W-1:0]  cfg_delay = '0;
  logic [7:0]        cfg_half = '0;
  logic [7:0]        cfg_gap = '0;
  logic [3:0]        cfg_pulses = '0;
  logic [ADDR_W-1:0] cfg_samples = '0;
  logic [4:0]        cfg_shots = '0;
  logic [ADC_W-1:0]  adc_data = '0;
  logic              EMA_PULSE_P;
  logic              EMA_PULSE_N;
  logic              ON_32;
  logic              CTRL_SW;
  logic [15:0]       FSMC_D;
  logic              busy;
  logic              done;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] p_vec, n_vec, on_vec;
  int          done_t;

  ema_burst_capture #(
    .ADC_W(ADC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_SHOTS(MAX_SHOTS)
  ) dut (
    .clk_80mhz   (clk_80mhz),
    .pll_locked  (pll_locked),
    .START_FPGA  (START_FPGA),
    .cfg_delay   (cfg_delay),
    .cfg_half    (cfg_half),
    .cfg_gap     (cfg_gap),
    .cfg_pulses  (cfg_pulses),
    .cfg_samples (cfg_samples),
    .cfg_shots   (cfg_shots),
    .adc_data    (adc_data),
    .EMA_PULSE_P (EMA_PULSE_P),
    .EMA_PULSE_N (EMA_PULSE_N),
    .ON_32       (ON_32),
    .CTRL_SW     (CTRL_SW),
    .FPGA_OE     (FPGA_OE),
    .FSMC_D      (FSMC_D),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_80mhz = ~clk_80mhz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Active-low waveform: bits inside either inclusive range are 0.
  function automatic logic [63:0] range_vec(input int lo1, input int hi1, input int lo2, input int hi2);
    logic [63:0] v;
    v = '1;
    for (int i = 0; i < 64; i++) begin
      if ((i >= lo1 && i <= hi1) || (i >= lo2 && i <= hi2)) v[i] = 1'b0;
    end
    return v;
  endfunction

  task automatic set_cfg(input int dly, input int h, input int g, input int np, input int ns, input int sh);
    cfg_delay   = CNT_W'(dly);
    cfg_half    = 8'(h);
    cfg_gap     = 8'(g);
    cfg_pulses  = 4'(np);
    cfg_samples = ADDR_W'(ns);
    cfg_shots   = 5'(sh);
  endtask

  task automatic pulse_start();
    START_FPGA = 1'b1;
    repeat (5) @(negedge clk_80mhz);
    START_FPGA = 1'b0;
  endtask

  // Returns on the negedge of the first BURST cycle (t=0).
  task automatic wait_p_fall(input string tag);
    bit seen_high = 1'b0;
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_80mhz);
      if (EMA_PULSE_P) seen_high = 1'b1;
      else if (seen_high) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // Record P/N/ON_32 from t=0 (current negedge) for len cycles, driving
  // adc_data with the sample index (ramp) or a constant, optionally pulsing START.
  task automatic record(input int len, input bit ramp, input int start_at, input logic [ADC_W-1:0] cval);
    p_vec = '1; n_vec = '1; on_vec = '1; done_t = -1;
    for (int t = 0; t < len; t++) begin
      if (t > 0) @(negedge clk_80mhz);
      adc_data   = ramp ? ADC_W'(t) : cval;
      START_FPGA = (start_at >= 0) && (t >= start_at) && (t < start_at + 4);
      if (t < 64) begin
        p_vec[t]  = EMA_PULSE_P;
        n_vec[t]  = EMA_PULSE_N;
        on_vec[t] = ON_32;
      end
      if (done && done_t < 0) done_t = t;
    end
    START_FPGA = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_80mhz);
      if (done && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
    repeat (4) @(negedge clk_80mhz);
  endtask

  task automatic fsmc_read(output logic [15:0] d);
    FPGA_OE = 1'b0;
    repeat (6) @(negedge clk_80mhz);
    d = FSMC_D;
    $display("fsmc read: data=%04h", d);
    FPGA_OE = 1'b1;
    repeat (6) @(negedge clk_80mhz);
  endtask

  initial begin
    logic [15:0] rd;
    int b, o, p, t;

    // ---------------- reset ----------------
    set_cfg(100, 10, 3, 2, 64, 1);
    repeat (3) @(negedge clk_80mhz);
    check("reset_outputs", {EMA_PULSE_P, EMA_PULSE_N, ON_32, CTRL_SW, busy, done, FSMC_D},
          {6'b111000, 16'h0000});
    pll_locked = 1'b1;
    repeat (2) @(negedge clk_80mhz);
    check("idle_after_reset", {busy, done, ON_32}, 3'b001);

    // ---------------- 1: defaults ----------------
    START_FPGA = 1'b1;
    b = -1; o = -1; p = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_80mhz);
      if (i == 4) START_FPGA = 1'b0;
      if (busy && b < 0) b = i;
      if (!ON_32 && o < 0) o = i;
      if (!EMA_PULSE_P) begin
        p = i;
        break;
      end
    end
    START_FPGA = 1'b0;
    check("t1_on32_fall_after_busy", 64'(o - b), 64'd1);
    check("t1_delay_to_p_fall", 64'(p - b), 64'd100);
    record(70, 1'b1, -1, '0);
    check("t1_p_wave", p_vec, range_vec(0, 9, 23, 32));
    check("t1_n_wave", n_vec, range_vec(10, 19, 33, 42));
    check("t1_on32_wave", on_vec, range_vec(0, 42, 1, 0));
    check("t1_done_time", 64'(done_t), 64'd66);
    wait_done("t1_done_timeout", 100);
    fsmc_read(rd); check("t1_word0", 64'(rd), 64'd0);
    fsmc_read(rd); check("t1_word1", 64'(rd), 64'd1);
    fsmc_read(rd); check("t1_word2", 64'(rd), 64'd2);

    // ---------------- 2: 16 shots of full-scale ----------------
    set_cfg(5, 4, 0, 1, 4, 16);
    adc_data = 12'hFFF;
    pulse_start();
    wait_done("t2_done_timeout", 3000);
    for (int k = 0; k < 4; k++) begin
      fsmc_read(rd);
      check($sformatf("t2_word%0d", k), 64'(rd), 64'hFFF0);
    end

    // ---------------- 3: ramp, 3 shots, 8 samples ----------------
    set_cfg(100, 10, 3, 1, 8, 3);
    pulse_start();
    for (int s = 0; s < 3; s++) begin
      wait_p_fall($sformatf("t3_p_fall_shot%0d", s));
      record(12, 1'b1, -1, '0);
    end
    wait_done("t3_done_timeout", 500);
    for (int k = 0; k < 8; k++) begin
      fsmc_read(rd);
      check($sformatf("t3_word%0d", k), 64'(rd), 64'(3 * k));
    end
    fsmc_read(rd);
    check("t3_wrap_word0", 64'(rd), 64'd0);

    // ---------------- 4: START during BURST, restart from DONE ----------------
    set_cfg(100, 10, 3, 2, 8, 1);
    pulse_start();
    check("t4_restart_done_low", {busy, done}, 2'b10);
    wait_p_fall("t4_p_fall");
    record(50, 1'b1, 5, '0);
    check("t4_p_wave", p_vec, range_vec(0, 9, 23, 32));
    check("t4_n_wave", n_vec, range_vec(10, 19, 33, 42));
    check("t4_on32_wave", on_vec, range_vec(0, 42, 1, 0));
    wait_done("t4_done_timeout", 300);
    fsmc_read(rd); check("t4_rdptr_cleared_word0", 64'(rd), 64'd0);
    fsmc_read(rd); check("t4_word1", 64'(rd), 64'd1);

    // ---------------- 5: reset pulse mid-CAPT ----------------
    set_cfg(100, 10, 3, 2, 64, 1);
    pulse_start();
    wait_p_fall("t5_p_fall");
    record(51, 1'b1, -1, '0);
    check("t5_in_capt_busy", {busy, done}, 2'b10);
    pll_locked = 1'b0;
    @(negedge clk_80mhz);
    check("t5_reset_outputs", {EMA_PULSE_P, EMA_PULSE_N, ON_32, CTRL_SW, busy, done, FSMC_D},
          {6'b111000, 16'h0000});
    pll_locked = 1'b1;
    repeat (3) @(negedge clk_80mhz);
    check("t5_stays_idle", {busy, done}, 2'b00);
    set_cfg(20, 2, 1, 1, 8, 1);
    adc_data = 12'h0AB;
    pulse_start();
    wait_done("t5_done_timeout", 300);
    fsmc_read(rd); check("t5_word0", 64'(rd), 64'h0AB);
    fsmc_read(rd); check("t5_word1", 64'(rd), 64'h0AB);

    // ---------------- 6: zero config -> minimum pulse, full depth ----------------
    set_cfg(4, 0, 0, 0, 0, 1);
    adc_data = 12'h055;
    pulse_start();
    wait_p_fall("t6_p_fall");
    record(6, 1'b0, -1, 12'h055);
    check("t6_p_wave", p_vec, range_vec(0, 0, 1, 0));
    check("t6_n_wave", n_vec, range_vec(1, 1, 1, 0));
    check("t6_on32_wave", on_vec, range_vec(0, 1, 1, 0));
    t = 5;
    done_t = -1;
    for (int i = 0; i < 16000; i++) begin
      @(negedge clk_80mhz);
      t++;
      if (done) begin
        done_t = t;
        break;
      end
    end
    check("t6_done_time_full_depth", 64'(done_t), 64'(DEPTH + 2));
    repeat (4) @(negedge clk_80mhz);
    fsmc_read(rd); check("t6_word0", 64'(rd), 64'h055);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
